// File: rtl/mac_keyboard_link.sv
// Keyboard end of the Mac Plus serial keyboard link: drives the link clock,
// shifts in host command bytes and answers them from a small key-code FIFO.
module mac_keyboard_link #(
    parameter int          TICK_DIV    = 8,
    parameter int          HALF_TICKS  = 10,
    parameter int          REQ_TICKS   = 2,
    parameter int          GAP_TICKS   = 20,
    parameter int          INQ_TIMEOUT = 2500,
    parameter logic [7:0]  MODEL_ID    = 8'h0B
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       host_data_i,
    output logic       kbd_clk_o,
    output logic       kbd_data_o,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int M1   = (HALF_TICKS > REQ_TICKS) ? HALF_TICKS : REQ_TICKS;
    localparam int M2   = (GAP_TICKS > INQ_TIMEOUT) ? GAP_TICKS : INQ_TIMEOUT;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RX_REQ, S_RX_SHIFT, S_DECODE, S_INQ_WAIT, S_TX_GAP, S_TX_SHIFT
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic            clk_q, clk_d, data_q, data_d;
    logic [7:0]      shift_q, shift_d, resp_q, resp_d, cmd_q, cmd_d;
    logic [7:0]      fifo_mem [4];
    logic [1:0]      wr_q, rd_q;
    logic [2:0]      count_q;
    logic            tick, push, pop, half_done, fifo_empty;
    logic [7:0]      head;

    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign fifo_empty = (count_q == 3'd0);
    assign push       = key_valid && (count_q != 3'd4);
    assign head       = fifo_mem[rd_q];
    assign half_done  = (cnt_q == CW'(HALF_TICKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    // NOTE: storage has no reset; the cleared pointers and count already make it empty.
    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_q] <= key_code;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 2'd1;
            if (pop)  rd_q <= rd_q + 2'd1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            shift_q <= '0;
            resp_q  <= '0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
            data_q  <= data_d;
            shift_q <= shift_d;
            resp_q  <= resp_d;
            cmd_q   <= cmd_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        data_d  = data_q;
        shift_d = shift_q;
        resp_d  = resp_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
                if (tick && !host_data_i) begin
                    state_d = S_RX_REQ;
                    cnt_d   = '0;
                end
            end
            S_RX_REQ: if (tick) begin
                if (host_data_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CW'(REQ_TICKS - 1)) begin
                    state_d = S_RX_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RX_SHIFT: if (tick) begin
                if (!half_done) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!clk_q) begin
                        // Host data is taken on the rising edge of the link clock.
                        clk_d          = 1'b1;
                        shift_d[bit_q] = host_data_i;
                        if (bit_q == 3'd0) begin
                            state_d = S_DECODE;
                            cmd_d   = {shift_q[7:1], host_data_i};
                        end
                    end else begin
                        clk_d = 1'b0;
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            S_DECODE: begin
                cnt_d   = '0;
                state_d = S_TX_GAP;
                case (cmd_q)
                    8'h10: begin
                        if (!fifo_empty) begin
                            pop    = 1'b1;
                            resp_d = head;
                        end else begin
                            state_d = S_INQ_WAIT;
                        end
                    end
                    8'h14: begin
                        pop    = !fifo_empty;
                        resp_d = fifo_empty ? 8'h7B : head;
                    end
                    8'h16:   resp_d  = MODEL_ID;
                    8'h36:   resp_d  = 8'h7D;
                    default: state_d = S_IDLE;
                endcase
            end
            S_INQ_WAIT: if (tick) begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    resp_d  = head;
                    state_d = S_TX_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(INQ_TIMEOUT - 1)) begin
                    resp_d  = 8'h7B;
                    state_d = S_TX_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TX_GAP: if (tick) begin
                if (cnt_q == CW'(GAP_TICKS - 1)) begin
                    state_d = S_TX_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 3'd7;
                    clk_d   = 1'b0;
                    data_d  = resp_q[7];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TX_SHIFT: if (tick) begin
                if (!half_done) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!clk_q) begin
                        clk_d = 1'b1;
                    end else if (bit_q == 3'd0) begin
                        state_d = S_IDLE;
                        data_d  = 1'b1;
                    end else begin
                        bit_d  = bit_q - 3'd1;
                        clk_d  = 1'b0;
                        data_d = resp_q[bit_q - 3'd1];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign kbd_clk_o  = clk_q;
    assign kbd_data_o = data_q;
    assign key_ready  = (count_q != 3'd4);
    assign busy       = (state_q != S_IDLE);
    assign cmd_valid  = (state_q == S_DECODE);
    assign cmd_byte   = cmd_q;

endmodule

// File: tb/tb_mac_keyboard_link.sv
// Self-checking bench for mac_keyboard_link: acts as the host VIA and compares
// every response byte and link timing against a queue-based model.
module tb_mac_keyboard_link;

    localparam int TICK_DIV    = 8;
    localparam int HALF_TICKS  = 10;
    localparam int GAP_TICKS   = 20;
    localparam int INQ_TIMEOUT = 2500;
    localparam int BIT_CYC     = HALF_TICKS * TICK_DIV;
    localparam int GAP_CYC     = GAP_TICKS * TICK_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       host_data_i = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       kbd_clk_o, kbd_data_o, key_ready, busy, cmd_valid;
    logic [7:0] cmd_byte;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_cmd = 0;
    logic [7:0] fifo_m[$];

    mac_keyboard_link dut (
        .clock      (clock),
        .reset      (reset),
        .host_data_i(host_data_i),
        .kbd_clk_o  (kbd_clk_o),
        .kbd_data_o (kbd_data_o),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .busy       (busy),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what a command must answer, given the keys queued so far.
    function automatic logic [7:0] model_resp(input logic [7:0] c);
        case (c)
            8'h10, 8'h14: return (fifo_m.size() != 0) ? fifo_m.pop_front() : 8'h7B;
            8'h16:        return 8'h0B;
            default:      return 8'h7D;
        endcase
    endfunction

    // Line rules checked on every cycle.
    logic prev_clk = 1'b1, prev_data = 1'b1, prev_busy = 1'b0;
    always @(negedge clock) begin
        if (!busy) check("idle_lines", {kbd_clk_o, kbd_data_o}, 2'b11);
        if (cmd_valid) check("cmd_valid_busy", busy, 1'b1);
        if (busy && prev_busy && kbd_clk_o && prev_clk) check("data_hold_high", kbd_data_o, prev_data);
        prev_clk  = kbd_clk_o;
        prev_data = kbd_data_o;
        prev_busy = busy;
    end

    task automatic wait_clk(input logic lvl, input int limit, output int n, output logic ok);
        n = 0;
        while (kbd_clk_o !== lvl && n < limit) begin
            @(negedge clock);
            n++;
        end
        ok = (kbd_clk_o === lvl);
    endtask

    task automatic push_key(input logic [7:0] c);
        @(negedge clock);
        key_valid = 1'b1;
        key_code  = c;
        if (fifo_m.size() < 4) fifo_m.push_back(c);
        @(negedge clock);
        key_valid = 1'b0;
        check("key_ready", key_ready, fifo_m.size() != 4);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        int n;
        logic ok;
        @(negedge clock);
        host_data_i = 1'b0;
        wait_clk(1'b0, 200, n, ok);
        check("rx_start", ok, 1'b1);
        if (!ok) begin
            host_data_i = 1'b1;
            return;
        end
        for (int i = 7; i >= 0; i--) begin
            host_data_i = c[i];
            wait_clk(1'b1, 200, n, ok);
            check("rx_low_len", n, BIT_CYC);
            if (i > 0) begin
                wait_clk(1'b0, 200, n, ok);
                check("rx_high_len", n, BIT_CYC);
            end
        end
        host_data_i = 1'b1;
        t_cmd = cyc;
        check("cmd_valid", cmd_valid, 1'b1);
        check("cmd_byte", cmd_byte, c);
    endtask

    task automatic recv_resp(output logic [7:0] r, input int exp_start, input int abort_bit);
        int n;
        logic d, unstable;
        r = 8'h00;
        unstable = 1'b0;
        n = 0;
        while (kbd_clk_o !== 1'b0 && n < exp_start + 200) begin
            @(negedge clock);
            n++;
        end
        check("resp_start", cyc - t_cmd, exp_start);
        if (kbd_clk_o !== 1'b0) return;
        for (int i = 7; i >= 0; i--) begin
            if (i == abort_bit) begin
                repeat (20) @(negedge clock);
                #2 reset = 1'b1;
                #1;
                check("rst_kbd_clk", kbd_clk_o, 1'b1);
                check("rst_kbd_data", kbd_data_o, 1'b1);
                check("rst_busy", busy, 1'b0);
                check("rst_key_ready", key_ready, 1'b1);
                check("rst_cmd_byte", cmd_byte, 8'h00);
                fifo_m.delete();
                @(negedge clock);
                reset = 1'b0;
                return;
            end
            d = kbd_data_o;
            n = 0;
            while (kbd_clk_o === 1'b0 && n < 200) begin
                if (kbd_data_o !== d) unstable = 1'b1;
                @(negedge clock);
                n++;
            end
            check("tx_low_len", n, BIT_CYC);
            r[i] = kbd_data_o;
            n = 0;
            while (kbd_clk_o === 1'b1 && busy === 1'b1 && n < 200) begin
                @(negedge clock);
                n++;
            end
            check("tx_high_len", n, BIT_CYC);
        end
        check("tx_done_idle", busy, 1'b0);
        check("tx_low_stable", unstable, 1'b0);
    endtask

    task automatic do_cmd(input logic [7:0] c, input string name);
        logic [7:0] r, e;
        send_cmd(c);
        e = model_resp(c);
        recv_resp(r, GAP_CYC, -1);
        check(name, r, e);
    endtask

    task automatic do_unknown(input logic [7:0] c);
        int falls;
        send_cmd(c);
        @(negedge clock);
        check("unk_busy_drop", busy, 1'b0);
        falls = 0;
        repeat (200) begin
            @(negedge clock);
            if (!kbd_clk_o) falls++;
        end
        check("unk_no_clock", falls, 0);
    endtask

    initial begin
        logic [7:0] r, c;
        int m, n_low, n_cv;

        // Reset values.
        repeat (2) @(negedge clock);
        check("reset_kbd_clk", kbd_clk_o, 1'b1);
        check("reset_kbd_data", kbd_data_o, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_cmd_valid", cmd_valid, 1'b0);
        check("reset_cmd_byte", cmd_byte, 8'h00);
        check("reset_key_ready", key_ready, 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Model command: literal 8'h0B.
        send_cmd(8'h16);
        recv_resp(r, GAP_CYC, -1);
        check("model_literal", r, 8'h0B);

        // Instant x3 with two keys queued.
        push_key(8'h21);
        push_key(8'h45);
        send_cmd(8'h14); void'(model_resp(8'h14)); recv_resp(r, GAP_CYC, -1);
        check("instant_1", r, 8'h21);
        send_cmd(8'h14); void'(model_resp(8'h14)); recv_resp(r, GAP_CYC, -1);
        check("instant_2", r, 8'h45);
        send_cmd(8'h14); recv_resp(r, GAP_CYC, -1);
        check("instant_3", r, 8'h7B);

        // Inquiry with nothing queued: null after the full timeout.
        send_cmd(8'h10);
        recv_resp(r, (INQ_TIMEOUT + GAP_TICKS) * TICK_DIV, -1);
        check("inquiry_timeout", r, 8'h7B);

        // Inquiry answered by a key arriving around tick 100.
        send_cmd(8'h10);
        m = 100 * TICK_DIV + $urandom_range(0, 7);
        repeat (m) @(negedge clock);
        key_valid = 1'b1;
        key_code  = 8'h33;
        fifo_m.push_back(8'h33);
        @(negedge clock);
        key_valid = 1'b0;
        recv_resp(r, ((m + 1) / TICK_DIV + 1) * TICK_DIV + GAP_CYC, -1);
        check("inquiry_key", r, 8'h33);
        check("inquiry_model", r, model_resp(8'h10));

        // Overflow: five back-to-back pushes, fifth dropped.
        for (int k = 0; k < 5; k++) begin
            c = 8'($urandom);
            key_valid = 1'b1;
            key_code  = c;
            if (fifo_m.size() < 4) fifo_m.push_back(c);
            @(negedge clock);
            check("ovf_key_ready", key_ready, fifo_m.size() != 4);
        end
        key_valid = 1'b0;
        for (int k = 0; k < 5; k++) do_cmd(8'h14, "ovf_instant");
        check("ovf_ready_after", key_ready, 1'b1);

        // Test and unknown commands.
        send_cmd(8'h36);
        recv_resp(r, GAP_CYC, -1);
        check("test_literal", r, 8'h7D);
        do_unknown(8'h99);
        do begin
            c = 8'($urandom);
        end while (c == 8'h10 || c == 8'h14 || c == 8'h16 || c == 8'h36);
        do_unknown(c);

        // One-tick glitch on the host line starts nothing.
        @(negedge clock);
        host_data_i = 1'b0;
        repeat (TICK_DIV) @(negedge clock);
        host_data_i = 1'b1;
        n_low = 0;
        n_cv  = 0;
        repeat (150) begin
            @(negedge clock);
            if (!kbd_clk_o) n_low++;
            if (cmd_valid) n_cv++;
        end
        check("glitch_no_clock", n_low, 0);
        check("glitch_no_cmd", n_cv, 0);
        check("glitch_idle", busy, 1'b0);

        // Random mix of queued keys and answering commands.
        for (int it = 0; it < 2; it++) begin
            repeat ($urandom_range(1, 2)) push_key(8'($urandom));
            case ($urandom_range(0, 3))
                0:       do_cmd(8'h10, "rand_inquiry");
                1:       do_cmd(8'h14, "rand_instant");
                2:       do_cmd(8'h16, "rand_model");
                default: do_cmd(8'h36, "rand_test");
            endcase
        end

        // Reset during bit 3 of a response, then the FIFO must be empty.
        push_key(8'h5A);
        send_cmd(8'h16);
        recv_resp(r, GAP_CYC, 3);
        repeat (5) @(negedge clock);
        send_cmd(8'h14);
        recv_resp(r, GAP_CYC, -1);
        check("post_reset_instant", r, 8'h7B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
